bullcow_display: RTL and testbench



---
 rtl/bullcow_display.sv | 198 +++++++++++++++++++
 tb/tb_bullcow_display.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bullcow_display.sv
// Bulls and Cows status renderer for an 8-digit multiplexed common-anode seven-segment display.
// Optional end-game blinking is enabled by defining BULLCOW_DISP_BLINK_EN.
module bullcow_display #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic [2:0] bull_count,
  input  logic [2:0] cow_count,
  input  logic [7:0] J1_points,
  input  logic [7:0] J2_points,
  output logic [7:0] an,
  output logic [7:0] dec_ddp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  localparam logic [2:0] ST_J1_SETUP = 3'b000;
  localparam logic [2:0] ST_J2_SETUP = 3'b001;
  localparam logic [2:0] ST_J1_GUESS = 3'b010;
  localparam logic [2:0] ST_J2_GUESS = 3'b011;
  localparam logic [2:0] ST_END      = 3'b111;

  // Glyphs in gfedcba order, bit 0 = segment a.
  localparam logic [6:0] G_BLANK = 7'h00;
  localparam logic [6:0] G_DASH  = 7'h40;
  localparam logic [6:0] G_LC_B  = 7'h7C;
  localparam logic [6:0] G_UC_C  = 7'h39;
  localparam logic [6:0] G_UC_E  = 7'h79;
  localparam logic [6:0] G_UC_J  = 7'h1E;
  localparam logic [6:0] G_UC_S  = 7'h6D;
  localparam logic [6:0] G_LC_T  = 7'h78;

  if (SCAN_DIV < 1 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("bullcow_display: SCAN_DIV and BLINK_FRAMES must both be at least 1");
  end

  typedef struct packed {
    logic [2:0] state;
    logic [2:0] bull;
    logic [2:0] cow;
    logic [7:0] p1;
    logic [7:0] p2;
  } snap_t;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  snap_t         snap;
  logic          scan_tick;
  logic          frame_end;
  logic          phase_on;
  logic [6:0]    glyph;
  logic [7:0]    an_next;
  logic [7:0]    seg_next;

  assign scan_tick = (presc == PRESC_LAST);
  assign frame_end = scan_tick && (idx == 3'd7);

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    g = G_BLANK;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (scan_tick) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Inputs are captured only at frame boundaries so a frame never mixes two status sets.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap <= '0;
    end else if (frame_end) begin
      snap.state <= game_state;
      snap.bull  <= bull_count;
      snap.cow   <= cow_count;
      snap.p1    <= J1_points;
      snap.p2    <= J2_points;
    end
  end

`ifdef BULLCOW_DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_on;

  // Counting requires end game both in the frame just finished and the one being loaded,
  // so the first end-game frame always starts visible and leaving end game never blanks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (game_state == ST_END && snap.state == ST_END) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end else begin
        frame_cnt <= '0;
        blink_on  <= 1'b1;
      end
    end
  end

  assign phase_on = blink_on;
`else
  assign phase_on = 1'b1;
`endif

  always_comb begin
    glyph = G_BLANK;
    case (snap.state)
      ST_J1_SETUP, ST_J2_SETUP: begin
        case (idx)
          3'd7: glyph = G_UC_J;
          3'd6: glyph = snap.state[0] ? hex_glyph(4'h2) : hex_glyph(4'h1);
          3'd4: glyph = G_UC_S;
          3'd3: glyph = G_UC_E;
          3'd2: glyph = G_LC_T;
          default: glyph = G_BLANK;
        endcase
      end
      ST_J1_GUESS, ST_J2_GUESS: begin
        case (idx)
          3'd7: glyph = G_UC_J;
          3'd6: glyph = snap.state[0] ? hex_glyph(4'h2) : hex_glyph(4'h1);
          3'd4: glyph = G_LC_B;
          3'd3: glyph = hex_glyph({1'b0, snap.bull});
          3'd1: glyph = G_UC_C;
          3'd0: glyph = hex_glyph({1'b0, snap.cow});
          default: glyph = G_BLANK;
        endcase
      end
      ST_END: begin
        case (idx)
          3'd7: glyph = hex_glyph(4'h1);
          3'd6: glyph = hex_glyph(snap.p1[7:4]);
          3'd5: glyph = hex_glyph(snap.p1[3:0]);
          3'd2: glyph = hex_glyph(4'h2);
          3'd1: glyph = hex_glyph(snap.p2[7:4]);
          3'd0: glyph = hex_glyph(snap.p2[3:0]);
          default: glyph = G_BLANK;
        endcase
      end
      default: glyph = G_DASH;
    endcase
  end

  // Pin order is {a..g,dp}, the reverse of the glyph encoding, all active-low.
  assign seg_next = ~{glyph[0], glyph[1], glyph[2], glyph[3], glyph[4], glyph[5], glyph[6], 1'b0};
  assign an_next  = phase_on ? ~(8'd1 << idx) : 8'hFF;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an      <= 8'hFF;
      dec_ddp <= 8'hFF;
    end else begin
      an      <= an_next;
      dec_ddp <= seg_next;
    end
  end

endmodule

// File: tb/tb_bullcow_display.sv
// Randomized and directed check of bullcow_display against a segment-list reference model.
module tb_bullcow_display;

  localparam int SD    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] game_state;
  logic [2:0] bull_count;
  logic [2:0] cow_count;
  logic [7:0] J1_points;
  logic [7:0] J2_points;
  logic [7:0] an;
  logic [7:0] dec_ddp;

  bullcow_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset(reset), .game_state(game_state),
    .bull_count(bull_count), .cow_count(cow_count),
    .J1_points(J1_points), .J2_points(J2_points),
    .an(an), .dec_ddp(dec_ddp)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what the current frame shows, as lists of lit segment letters.
  int         edge_no;
  logic [2:0] m_state, m_bull, m_cow;
  logic [7:0] m_p1, m_p2;
  int         m_run;
  string hexseg[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic string glyph_of(int d);
    string g;
    g = "";
    case (m_state)
      3'b000, 3'b001: begin
        if (d == 7) g = "bcde";
        if (d == 6) g = (m_state == 3'b000) ? hexseg[1] : hexseg[2];
        if (d == 4) g = "acdfg";
        if (d == 3) g = "adefg";
        if (d == 2) g = "defg";
      end
      3'b010, 3'b011: begin
        if (d == 7) g = "bcde";
        if (d == 6) g = (m_state == 3'b010) ? hexseg[1] : hexseg[2];
        if (d == 4) g = "cdefg";
        if (d == 3) g = hexseg[int'(m_bull)];
        if (d == 1) g = "adef";
        if (d == 0) g = hexseg[int'(m_cow)];
      end
      3'b111: begin
        if (d == 7) g = hexseg[1];
        if (d == 6) g = hexseg[int'(m_p1[7:4])];
        if (d == 5) g = hexseg[int'(m_p1[3:0])];
        if (d == 2) g = hexseg[2];
        if (d == 1) g = hexseg[int'(m_p2[7:4])];
        if (d == 0) g = hexseg[int'(m_p2[3:0])];
      end
      default: g = "g";
    endcase
    return g;
  endfunction

  function automatic logic [7:0] pins_of(string s);
    logic [7:0] r;
    r = 8'hFF;
    for (int i = 0; i < s.len(); i++) begin
      int k;
      k = int'(s[i]) - 97;
      r[7-k] = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    edge_no = 0;
    m_state = 3'b000; m_bull = '0; m_cow = '0; m_p1 = '0; m_p2 = '0;
    m_run = 0;
  endtask

  function automatic int cur_digit();
    return (edge_no / SD) % 8;
  endfunction

  // One clock: predict the pins loaded on this edge, advance the model, compare at negedge.
  task automatic step();
    int         d;
    bit         vis;
    logic [7:0] exp_an, exp_seg;
    @(posedge clock);
    d = cur_digit();
    vis = 1'b1;
`ifdef BULLCOW_DISP_BLINK_EN
    if (m_state == 3'b111) vis = ((m_run / BF) % 2) == 0;
`endif
    exp_an  = vis ? ~(8'd1 << d) : 8'hFF;
    exp_seg = pins_of(glyph_of(d));
    edge_no++;
    if (edge_no % FRAME == 0) begin
      m_run = (m_state == 3'b111 && game_state == 3'b111) ? m_run + 1 : 0;
      m_state = game_state; m_bull = bull_count; m_cow = cow_count;
      m_p1 = J1_points; m_p2 = J2_points;
    end
    @(negedge clock);
    check("an", an, exp_an);
    check("dec_ddp", dec_ddp, exp_seg);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    game_state = 3'b000; bull_count = '0; cow_count = '0; J1_points = '0; J2_points = '0;
    model_reset();
    #3;
    check("reset_an", an, 8'hFF);
    check("reset_seg", dec_ddp, 8'hFF);
    @(negedge clock); @(negedge clock);
    check("reset_hold_an", an, 8'hFF);
    reset = 1'b0;

    // Setup screen with directed spot checks at d0, d6, d7.
    for (int i = 1; i <= 2 * FRAME; i++) begin
      step();
      if (i == 1)  begin check("first_an", an, 8'hFE); check("first_seg", dec_ddp, 8'hFF); end
      if (i == 13) begin check("d6_an", an, 8'hBF); check("d6_seg", dec_ddp, 8'h9F); end
      if (i == 15) begin check("d7_an", an, 8'h7F); check("d7_seg", dec_ddp, 8'h87); end
      if (i == 17) check("wrap_an", an, 8'hFE);
    end

    game_state = 3'b010; bull_count = 3'd2; cow_count = 3'd1;
    run(2 * FRAME);

    // Mid-frame change must not leak into the rest of the frame.
    game_state = 3'b000;
    run(FRAME);
    while (cur_digit() != 3) step();
    game_state = 3'b011; bull_count = 3'($urandom_range(0, 7)); cow_count = 3'($urandom_range(0, 7));
    run(2 * FRAME);

    game_state = 3'b111; J1_points = 8'h0A; J2_points = 8'h03;
    run(8 * FRAME);

    game_state = 3'b100;
    run(2 * FRAME);

    for (int k = 0; k < 24; k++) begin
      game_state = 3'($urandom_range(0, 7));
      if (k % 4 == 0) game_state = 3'b111;
      bull_count = 3'($urandom_range(0, 7));
      cow_count  = 3'($urandom_range(0, 7));
      J1_points  = 8'($urandom_range(0, 255));
      J2_points  = 8'($urandom_range(0, 255));
      run($urandom_range(5, 6 * FRAME));
    end

    // Asynchronous reset mid-frame.
    game_state = 3'b010;
    run(2 * FRAME);
    while (cur_digit() != 5) step();
    #2 reset = 1'b1;
    #1;
    check("async_an", an, 8'hFF);
    check("async_seg", dec_ddp, 8'hFF);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    step();
    check("restart_an", an, 8'hFE);
    run(3 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
